tsf_timer_mc: RTL and testbench

Parametrised multi-channel TSF timer: a TIMER_WIDTH-bit microsecond time-synchronisation-function counter derived from the xpu clock by programmable prescalers. Successor to the single-channel TSF timer, adding absolute/offset load modes, software capture, and N_CMP armable compare channels with optional periodic reload for TBTT/beacon and slot scheduling. Sits in xpu; drives the 1 MHz/20 MHz strobes and beacon/event timing to tx_control and csma.

---
 rtl/tsf_timer_mc.sv | 134 +++++++++++++
 tb/tb_tsf_timer_mc.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsf_timer_mc.sv
// Multi-channel TSF microsecond timer: prescaled counter with absolute/offset load, capture,
// and armable compare channels with periodic reload and catch-up miss reporting.
module tsf_timer_mc #(
    parameter int unsigned TIMER_WIDTH   = 64,
    parameter int unsigned TICKS_PER_US  = 100,
    parameter int unsigned TICKS_PER_20M = 5,
    parameter int unsigned N_CMP         = 2,
    parameter int unsigned PERIOD_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            tsf_load_control,
    input  logic                            tsf_load_mode,
    input  logic [TIMER_WIDTH-1:0]          tsf_load_val,
    input  logic                            reset_tsf,
    input  logic                            capture,
    input  logic [N_CMP-1:0]                cmp_arm,
    input  logic [N_CMP-1:0]                cmp_disarm,
    input  logic [N_CMP*TIMER_WIDTH-1:0]    cmp_target,
    input  logic [N_CMP*PERIOD_WIDTH-1:0]   cmp_period,
    output logic [TIMER_WIDTH-1:0]          tsf_runtime_val,
    output logic [TIMER_WIDTH-1:0]          tsf_log_val,
    output logic [TIMER_WIDTH-1:0]          tsf_capture_val,
    output logic                            tsf_pulse_1M,
    output logic                            tsf_pulse_20M,
    output logic [N_CMP-1:0]                cmp_active,
    output logic [N_CMP-1:0]                cmp_event,
    output logic [N_CMP-1:0]                cmp_miss
);

    localparam logic [7:0] US_LAST  = 8'(TICKS_PER_US - 1);
    localparam logic [7:0] P20_LAST = 8'(TICKS_PER_20M - 1);

    logic [7:0]              cnt_us;
    logic [7:0]              cnt_20;
    logic                    load_q;
    logic                    load_commit;
    logic [TIMER_WIDTH-1:0]  target_q    [N_CMP];
    logic [PERIOD_WIDTH-1:0] period_q    [N_CMP];
    logic [TIMER_WIDTH-1:0]  next_target [N_CMP];
    logic [N_CMP-1:0]        catch_up_q;

    always_comb begin
        load_commit = load_q & ~tsf_load_control;
        for (int i = 0; i < N_CMP; i++) begin
            next_target[i] = target_q[i] + TIMER_WIDTH'(period_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_us          <= '0;
            cnt_20          <= '0;
            load_q          <= 1'b0;
            tsf_runtime_val <= '0;
            tsf_log_val     <= '0;
            tsf_capture_val <= '0;
            tsf_pulse_1M    <= 1'b0;
            tsf_pulse_20M   <= 1'b0;
            cmp_active      <= '0;
            cmp_event       <= '0;
            cmp_miss        <= '0;
            catch_up_q      <= '0;
            for (int i = 0; i < N_CMP; i++) begin
                target_q[i] <= '0;
                period_q[i] <= '0;
            end
        end else begin
            tsf_pulse_1M  <= 1'b0;
            tsf_pulse_20M <= 1'b0;
            if (capture) begin
                tsf_capture_val <= tsf_runtime_val;
            end

            if (reset_tsf) begin
                tsf_log_val     <= tsf_runtime_val;
                tsf_runtime_val <= '0;
                cnt_us          <= '0;
                cnt_20          <= '0;
                load_q          <= 1'b0;
            end else begin
                load_q <= tsf_load_control;
                if (load_commit) begin
                    // A tick coinciding with the commit is intentionally dropped.
                    tsf_runtime_val <= tsf_load_mode ? tsf_runtime_val + tsf_load_val
                                                     : tsf_load_val;
                    cnt_us <= '0;
                    cnt_20 <= '0;
                end else begin
                    if (cnt_us == US_LAST) begin
                        cnt_us          <= '0;
                        tsf_runtime_val <= tsf_runtime_val + TIMER_WIDTH'(1);
                        tsf_pulse_1M    <= 1'b1;
                    end else begin
                        cnt_us <= cnt_us + 8'd1;
                    end
                    if (cnt_20 == P20_LAST) begin
                        cnt_20        <= '0;
                        tsf_pulse_20M <= 1'b1;
                    end else begin
                        cnt_20 <= cnt_20 + 8'd1;
                    end
                end
            end

            for (int i = 0; i < N_CMP; i++) begin
                cmp_event[i] <= 1'b0;
                cmp_miss[i]  <= 1'b0;
                if (reset_tsf) begin
                    cmp_active[i] <= 1'b0;
                    catch_up_q[i] <= 1'b0;
                end else if (cmp_arm[i]) begin
                    target_q[i]   <= cmp_target[i*TIMER_WIDTH +: TIMER_WIDTH];
                    period_q[i]   <= cmp_period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
                    cmp_active[i] <= 1'b1;
                    catch_up_q[i] <= 1'b0;
                end else if (cmp_disarm[i]) begin
                    cmp_active[i] <= 1'b0;
                end else if (cmp_active[i] && (tsf_runtime_val >= target_q[i])) begin
                    // While catching up, each skipped period produces a miss instead of an event.
                    cmp_event[i] <= ~catch_up_q[i];
                    cmp_miss[i]  <= catch_up_q[i];
                    if (period_q[i] == '0) begin
                        cmp_active[i] <= 1'b0;
                    end else begin
                        target_q[i]   <= next_target[i];
                        catch_up_q[i] <= (tsf_runtime_val >= next_target[i]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tsf_timer_mc.sv
// Scoreboard bench for tsf_timer_mc: an arithmetic reference model predicts per-cycle outputs and
// compare pulses; a negedge monitor pops and checks them against the DUT.
module tb_tsf_timer_mc;

    localparam int unsigned TW  = 64;
    localparam int unsigned TUS = 100;
    localparam int unsigned T20 = 5;
    localparam int unsigned NC  = 2;
    localparam int unsigned PW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              tsf_load_control;
    logic              tsf_load_mode;
    logic [TW-1:0]     tsf_load_val;
    logic              reset_tsf;
    logic              capture;
    logic [NC-1:0]     cmp_arm;
    logic [NC-1:0]     cmp_disarm;
    logic [NC*TW-1:0]  cmp_target;
    logic [NC*PW-1:0]  cmp_period;
    logic [TW-1:0]     tsf_runtime_val;
    logic [TW-1:0]     tsf_log_val;
    logic [TW-1:0]     tsf_capture_val;
    logic              tsf_pulse_1M;
    logic              tsf_pulse_20M;
    logic [NC-1:0]     cmp_active;
    logic [NC-1:0]     cmp_event;
    logic [NC-1:0]     cmp_miss;

    tsf_timer_mc #(
        .TIMER_WIDTH  (TW),
        .TICKS_PER_US (TUS),
        .TICKS_PER_20M(T20),
        .N_CMP        (NC),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .tsf_load_control(tsf_load_control),
        .tsf_load_mode   (tsf_load_mode),
        .tsf_load_val    (tsf_load_val),
        .reset_tsf       (reset_tsf),
        .capture         (capture),
        .cmp_arm         (cmp_arm),
        .cmp_disarm      (cmp_disarm),
        .cmp_target      (cmp_target),
        .cmp_period      (cmp_period),
        .tsf_runtime_val (tsf_runtime_val),
        .tsf_log_val     (tsf_log_val),
        .tsf_capture_val (tsf_capture_val),
        .tsf_pulse_1M    (tsf_pulse_1M),
        .tsf_pulse_20M   (tsf_pulse_20M),
        .cmp_active      (cmp_active),
        .cmp_event       (cmp_event),
        .cmp_miss        (cmp_miss)
    );

    typedef struct packed {
        logic [63:0]   tsf;
        logic [63:0]   log_v;
        logic [63:0]   cap;
        logic          p1;
        logic          p20;
        logic [NC-1:0] act;
    } snap_t;

    typedef struct packed {
        logic [63:0] cyc;
        logic [7:0]  ch;
        logic        miss;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: TSF is base + elapsed_edges / TUS since the last epoch (reset/load).
    longint unsigned m_cyc = 0;
    logic [63:0]     m_base = '0;
    longint unsigned m_epoch = 0;
    logic [63:0]     m_tsf = '0;
    logic [63:0]     m_log = '0;
    logic [63:0]     m_cap = '0;
    logic            m_lc = 1'b0;
    logic            m_act [NC];
    logic [63:0]     m_tgt [NC];
    logic [63:0]     m_per [NC];
    longint          m_busy [NC];
    logic [63:0]     mv;
    logic [63:0]     mk;
    snap_t           ms;
    snap_t           mon_s;

    initial begin
        for (int i = 0; i < NC; i++) begin
            m_act[i]  = 1'b0;
            m_tgt[i]  = '0;
            m_per[i]  = '0;
            m_busy[i] = -1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, m_cyc, got, exp);
        end
    endtask

    function automatic void flush(input int ch, input longint unsigned from);
        for (int k = ev_q.size() - 1; k >= 0; k--) begin
            if (ev_q[k].ch == 8'(ch) && ev_q[k].cyc >= from) ev_q.delete(k);
        end
    endfunction

    always @(posedge clk) begin
        m_cyc++;
        mv = m_tsf;
        if (!rstn) begin
            m_base = '0; m_epoch = m_cyc; m_log = '0; m_cap = '0; m_lc = 1'b0;
            for (int i = 0; i < NC; i++) begin
                m_act[i] = 1'b0; m_busy[i] = -1; flush(i, m_cyc);
            end
        end else begin
            if (capture) m_cap = mv;
            if (reset_tsf) begin
                m_log = mv; m_base = '0; m_epoch = m_cyc; m_lc = 1'b0;
                for (int i = 0; i < NC; i++) begin
                    m_act[i] = 1'b0; m_busy[i] = -1; flush(i, m_cyc);
                end
            end else begin
                if (m_lc && !tsf_load_control) begin
                    m_base  = tsf_load_mode ? mv + tsf_load_val : tsf_load_val;
                    m_epoch = m_cyc;
                end
                m_lc = tsf_load_control;
                for (int i = 0; i < NC; i++) begin
                    if (cmp_arm[i]) begin
                        flush(i, m_cyc);
                        m_act[i] = 1'b1; m_busy[i] = -1;
                        m_tgt[i] = cmp_target[i*TW +: TW];
                        m_per[i] = 64'(cmp_period[i*PW +: PW]);
                    end else if (cmp_disarm[i]) begin
                        flush(i, m_cyc);
                        m_act[i] = 1'b0; m_busy[i] = -1;
                    end else if (m_act[i] && longint'(m_cyc) > m_busy[i] && mv >= m_tgt[i]) begin
                        if (m_per[i] == '0) begin
                            ev_q.push_back('{cyc: m_cyc, ch: 8'(i), miss: 1'b0});
                            m_act[i] = 1'b0;
                        end else begin
                            // Every period already passed beyond the first is reported as a miss.
                            mk = (mv - m_tgt[i]) / m_per[i] + 64'd1;
                            for (longint unsigned j = 0; j < mk; j++) begin
                                ev_q.push_back('{cyc: m_cyc + j, ch: 8'(i), miss: (j != 0)});
                            end
                            m_tgt[i]  = m_tgt[i] + mk * m_per[i];
                            m_busy[i] = longint'(m_cyc + mk - 1);
                        end
                    end
                end
            end
        end
        m_tsf = m_base + (m_cyc - m_epoch) / TUS;
        ms.tsf   = m_tsf;
        ms.log_v = m_log;
        ms.cap   = m_cap;
        ms.p1    = (m_cyc > m_epoch) && ((m_cyc - m_epoch) % TUS == 0);
        ms.p20   = (m_cyc > m_epoch) && ((m_cyc - m_epoch) % T20 == 0);
        for (int i = 0; i < NC; i++) ms.act[i] = m_act[i];
        snap_q.push_back(ms);
    end

    always @(negedge clk) begin
        int found;
        if (snap_q.size() != 0) begin
            mon_s = snap_q.pop_front();
            chk("tsf_runtime_val", tsf_runtime_val, mon_s.tsf);
            chk("tsf_pulse_1M", 64'(tsf_pulse_1M), 64'(mon_s.p1));
            chk("tsf_pulse_20M", 64'(tsf_pulse_20M), 64'(mon_s.p20));
            chk("tsf_log_val", tsf_log_val, mon_s.log_v);
            chk("tsf_capture_val", tsf_capture_val, mon_s.cap);
            chk("cmp_active", 64'(cmp_active), 64'(mon_s.act));
        end
        for (int i = 0; i < NC; i++) begin
            if (cmp_event[i] || cmp_miss[i]) begin
                found = -1;
                for (int k = 0; k < ev_q.size(); k++) begin
                    if (found < 0 && ev_q[k].cyc == m_cyc && ev_q[k].ch == 8'(i)) found = k;
                end
                n_tests++;
                if (found < 0) begin
                    n_fail++;
                    $display("FAIL cmp_pulse ch%0d at edge %0d: got event=%0b miss=%0b expected none",
                             i, m_cyc, cmp_event[i], cmp_miss[i]);
                end else begin
                    if ((cmp_event[i] && cmp_miss[i]) || cmp_miss[i] != ev_q[found].miss) begin
                        n_fail++;
                        $display("FAIL cmp_kind ch%0d at edge %0d: got event=%0b miss=%0b expected miss=%0b",
                                 i, m_cyc, cmp_event[i], cmp_miss[i], ev_q[found].miss);
                    end
                    ev_q.delete(found);
                end
            end
        end
        for (int k = ev_q.size() - 1; k >= 0; k--) begin
            if (ev_q[k].cyc <= m_cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL cmp_missing ch%0d at edge %0d: got no pulse expected miss=%0b",
                         ev_q[k].ch, ev_q[k].cyc, ev_q[k].miss);
                ev_q.delete(k);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic mode, input logic [63:0] val);
        tsf_load_mode    = mode;
        tsf_load_val     = val;
        tsf_load_control = 1'b1;
        step(1);
        tsf_load_control = 1'b0;
        step(1);
    endtask

    task automatic do_arm(input int ch, input logic [63:0] tgt, input logic [31:0] per);
        cmp_target[ch*TW +: TW] = tgt;
        cmp_period[ch*PW +: PW] = per;
        cmp_arm[ch] = 1'b1;
        step(1);
        cmp_arm[ch] = 1'b0;
    endtask

    task automatic do_reset_tsf();
        reset_tsf = 1'b1;
        step(1);
        reset_tsf = 1'b0;
    endtask

    function automatic bit none_busy();
        bit ok = 1'b1;
        for (int i = 0; i < NC; i++) if (m_busy[i] > longint'(m_cyc)) ok = 1'b0;
        return ok;
    endfunction

    initial begin
        int r;
        int ch;
        int d;
        logic [63:0] dv;
        rstn = 1'b0; tsf_load_control = 1'b0; tsf_load_mode = 1'b0; tsf_load_val = '0;
        reset_tsf = 1'b0; capture = 1'b0; cmp_arm = '0; cmp_disarm = '0;
        cmp_target = '0; cmp_period = '0;
        step(3);
        rstn = 1'b1;
        step(1000);
        chk("free_run_1000", tsf_runtime_val, 64'd10);

        do_load(1'b0, 64'd7);
        do_load(1'b0, 64'h1000);
        chk("abs_load", tsf_runtime_val, 64'h1000);
        step(99);
        chk("abs_load_hold", tsf_runtime_val, 64'h1000);
        step(1);
        chk("abs_load_first_inc", tsf_runtime_val, 64'h1001);
        do_load(1'b0, 64'd5);
        do_load(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("offset_load_wrap", tsf_runtime_val, 64'd4);

        do_reset_tsf();
        do_load(1'b0, 64'd15);
        do_arm(0, 64'd20, 32'd0);
        step(600);

        do_reset_tsf();
        do_arm(1, 64'd10, 32'd100);
        do_load(1'b0, 64'd8);
        step(250);
        do_load(1'b0, 64'd108);
        step(250);
        do_load(1'b0, 64'd208);
        step(250);
        do_load(1'b0, 64'd605);
        step(10);
        do_load(1'b0, 64'd608);
        step(250);

        do_arm(0, 64'd1000, 32'd0);
        do_arm(1, 64'd2000, 32'd50);
        do_load(1'b0, 64'd333);
        reset_tsf = 1'b1;
        capture   = 1'b1;
        step(1);
        reset_tsf = 1'b0;
        capture   = 1'b0;
        chk("reset_tsf_log", tsf_log_val, 64'd333);
        chk("reset_tsf_capture", tsf_capture_val, 64'd333);
        chk("reset_tsf_zero", tsf_runtime_val, 64'd0);
        chk("reset_tsf_disarm", 64'(cmp_active), 64'd0);

        do_arm(0, 64'd50, 32'd0);
        do_arm(1, 64'd60, 32'd5);
        step(37);
        rstn = 1'b0;
        step(1);
        chk("rstn_tsf", tsf_runtime_val, 64'd0);
        chk("rstn_log", tsf_log_val, 64'd0);
        chk("rstn_capture", tsf_capture_val, 64'd0);
        chk("rstn_active", 64'(cmp_active), 64'd0);
        rstn = 1'b1;
        step(2);

        do_arm(0, 64'd50, 32'd0);
        do_load(1'b0, 64'd50);
        do_arm(0, 64'd80, 32'd0);
        chk("arm_beats_hit_event", 64'(cmp_event[0]), 64'd0);
        chk("arm_beats_hit_active", 64'(cmp_active[0]), 64'd1);
        do_load(1'b0, 64'd79);
        step(150);

        for (int it = 0; it < 2500; it++) begin
            r  = int'($urandom_range(0, 99));
            ch = int'($urandom_range(0, NC - 1));
            if (r < 8) begin
                do_arm(ch, m_tsf + 64'($urandom_range(1, 20)),
                       ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 20)));
            end else if (r < 11) begin
                cmp_disarm[ch] = 1'b1;
                step(1);
                cmp_disarm[ch] = 1'b0;
            end else if (r < 14 && none_busy()) begin
                d = int'($urandom_range(0, 120)) - 60;
                if (m_tsf < 64'd64 && d < 0) d = -d;
                dv = {{32{d[31]}}, d};
                if ($urandom_range(0, 1) == 1) do_load(1'b1, dv);
                else do_load(1'b0, m_tsf + dv);
            end else if (r < 15) begin
                do_reset_tsf();
            end else if (r < 20) begin
                capture = 1'b1;
                step(1);
                capture = 1'b0;
            end
            step(1);
        end

        step(200);
        chk("pending_events_drained", 64'(ev_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
